// File: rtl/demux_pkg.sv
// Shared constants and helpers for the demux_stream stream demultiplexer.
package demux_pkg;

    localparam int unsigned MAX_OUT = 16;
    localparam int unsigned CNT_W_DEFAULT = 16;
    localparam logic [CNT_W_DEFAULT-1:0] CNT_SAT = '1;

    function automatic logic sel_in_range(input logic [31:0] sel, input int unsigned n);
        return (sel < n);
    endfunction

endpackage

// File: rtl/demux_chan_reg.sv
// One-entry valid/data holding slice for a single demux output channel.
module demux_chan_reg #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    // A load wins over a drain, so back-to-back beats never leave a gap cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/demux_stream.sv
// Registered 1-to-NUM_OUT valid/ready stream demultiplexer with dropped-beat accounting.
// Optional broadcast to all channels is enabled by defining DEMUX_BCAST_EN.
module demux_stream
    import demux_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned NUM_OUT = 4,
    parameter int unsigned SEL_W   = 2,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [SEL_W-1:0]         in_sel,
`ifdef DEMUX_BCAST_EN
    input  logic                     in_bcast,
`endif
    output logic [NUM_OUT-1:0]       out_valid,
    input  logic [NUM_OUT-1:0]       out_ready,
    output logic [NUM_OUT*WIDTH-1:0] out_data,
    output logic                     sel_err,
    output logic [CNT_W-1:0]         drop_cnt
);

    logic [NUM_OUT-1:0] ch_free;
    logic [NUM_OUT-1:0] load;
    logic               sel_ok;
    logic               sel_ready;
    logic               bcast;
    logic               fire;
    logic               drop;

`ifdef DEMUX_BCAST_EN
    assign bcast = in_bcast;
`else
    assign bcast = 1'b0;
`endif

    assign ch_free = ~out_valid | out_ready;
    assign sel_ok  = sel_in_range(32'(in_sel), NUM_OUT);

    // Decode by comparison rather than indexing so out-of-range selects never address past ch_free.
    always_comb begin
        sel_ready = 1'b1;
        for (int unsigned k = 0; k < NUM_OUT; k++) begin
            if (in_sel == SEL_W'(k))
                sel_ready = ch_free[k];
        end
    end

    assign in_ready = bcast ? (&ch_free) : sel_ready;
    assign fire     = in_valid & in_ready;
    assign drop     = fire & ~bcast & ~sel_ok;

    always_comb begin
        load = '0;
        for (int unsigned k = 0; k < NUM_OUT; k++) begin
            load[k] = fire & (bcast | (in_sel == SEL_W'(k)));
        end
    end

    for (genvar k = 0; k < NUM_OUT; k++) begin : g_ch
        demux_chan_reg #(
            .WIDTH(WIDTH)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .load     (load[k]),
            .load_data(in_data),
            .ready    (out_ready[k]),
            .valid    (out_valid[k]),
            .data     (out_data[k*WIDTH +: WIDTH])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_err  <= 1'b0;
            drop_cnt <= '0;
        end else begin
            sel_err <= drop;
            if (drop && (drop_cnt != '1))
                drop_cnt <= drop_cnt + 1'b1;
        end
    end

endmodule
